// File: rtl/sum_acc_pkg.sv
// ---------------------------------------------------------------------------
// sum_acc_pkg
// Shared types and constants for the sum_accumulator block.
//   acc_state_e : accumulator FSM states (IDLE, ACCUM, HOLD)
//   clog2       : constant ceiling-log2, used to size the accumulator/counter
//   DEF_*       : default IN_WIDTH / COUNT_MAX
// ---------------------------------------------------------------------------
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    localparam int DEF_IN_WIDTH  = 27;
    localparam int DEF_COUNT_MAX = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sum_acc_counter.sv
// ---------------------------------------------------------------------------
// sum_acc_counter
// Beat counter for one accumulation block.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one accepted beat
//   clr        : return to zero (wins over inc)
//   count      : beats accepted so far in the current block
//   last       : the next accepted beat completes the block
// ---------------------------------------------------------------------------
module sum_acc_counter #(
    parameter int COUNT_MAX = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // The completing beat is never counted into the register; the top adds
    // it when loading out_count, so count stays below COUNT_MAX.
    assign last = (count == CNT_WIDTH'(COUNT_MAX - 1));

endmodule

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
// Sums COUNT_MAX successive tree results into one wide total and presents it
// on a valid/ready port. The accumulator is wide enough that no block can
// overflow.
//
// Optional feature: define ACC_FLUSH_EN to add the flush port, which closes a
// partial block early.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   in_valid    : in_data carries a tree sum
//   in_data     : unsigned tree sum
//   in_ready    : a beat can be accepted (state only)
//   clear       : discard the partial block (ignored while holding a result)
//   flush       : close the partial block early (ACC_FLUSH_EN only)
//   out_valid   : out_data/out_count hold a block result
//   out_data    : block total
//   out_count   : beats summed into out_data
//   out_ready   : consumer accepts the result
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no beats in the current block (count = 0)
// ACCUM | 0 < count < COUNT_MAX, partial sum in acc
// HOLD  | result presented on out_*, waiting for out_ready
// ---------------------------------------------------------------------------
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter  int IN_WIDTH  = DEF_IN_WIDTH,
    parameter  int COUNT_MAX = DEF_COUNT_MAX,
    localparam int ACC_WIDTH = IN_WIDTH + clog2(COUNT_MAX),
    localparam int CNT_WIDTH = clog2(COUNT_MAX) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    input  logic                 clear,
`ifdef ACC_FLUSH_EN
    input  logic                 flush,
`endif
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    input  logic                 out_ready
);

    acc_state_e           state;
    acc_state_e           state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] beat_sum;
    logic [CNT_WIDTH-1:0] count;
    logic                 cnt_last;
    logic                 beat;
    logic                 flush_req;
    logic                 acc_clr;
    logic                 acc_add;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic                 out_load;

`ifdef ACC_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign beat      = in_valid & in_ready;

    // Running total including the beat offered this cycle; this is both the
    // next accumulator value and the value captured when a block closes.
    assign beat_sum = acc + (beat ? ACC_WIDTH'(in_data) : '0);

    sum_acc_counter #(
        .COUNT_MAX (COUNT_MAX),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (count),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        out_load  = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (clear) begin
                    acc_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if ((beat && cnt_last) ||
                             (flush_req && (beat || (state == ACCUM)))) begin
                    // acc/count keep their values until the handshake.
                    out_load  = 1'b1;
                    state_nxt = HOLD;
                end else if (beat) begin
                    acc_add   = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                acc_clr   = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (acc_add) begin
            acc <= beat_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_count <= '0;
        end else if (out_load) begin
            out_data  <= beat_sum;
            out_count <= count + CNT_WIDTH'(beat);
        end
    end

endmodule
